vga_pixel_fetch: RTL and testbench

Upstream pixel source for the VGA timing generator: streams one frame of 24-bit RGB pixels from a framebuffer memory port into a small FIFO and delivers one pixel to the generator's `color_in` each cycle the generator reports `active`. Frame alignment comes from the generator's `screenend` pulse. Reads are prefetched through an in-order, variable-latency request/response port, and a sticky flag reports any underflow.

---
 rtl/vga_pixel_fetch.sv | 129 ++++++++++++
 tb/tb_vga_pixel_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel prefetcher for the VGA timing generator: pulls one frame of RGB words
// from an in-order memory port into a small FIFO and hands one pixel per active cycle.
module vga_pixel_fetch #(
  parameter int          H_VISIBLE       = 1024,
  parameter int          V_VISIBLE       = 768,
  parameter int          ADDR_W          = 20,
  parameter logic [ADDR_W-1:0] FB_BASE   = '0,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF,
  localparam int         LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              screenend,
  input  logic              active,
  output logic [23:0]       color_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [23:0]       mem_rdata,
  output logic              underflow,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [1:0]        dbg_state
);

  localparam int TOTAL  = H_VISIBLE * V_VISIBLE;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PIX_W  = $clog2(TOTAL + 1);
  localparam int DISC_W = LVL_W + 2;
  localparam logic [LVL_W:0]   DEPTH_L  = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [23:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LVL_W-1:0]   outstanding;
  logic [DISC_W-1:0]  discard;
  logic [PIX_W-1:0]   pix_cnt;

  logic               accept;
  logic               ret_live;
  logic               do_push;
  logic               do_pop;
  logic [LVL_W:0]     committed;
  logic [DISC_W-1:0]  stale;
  logic [DISC_W-1:0]  stale_next;

  assign dbg_state = state;
  assign committed = {1'b0, fifo_level} + {1'b0, outstanding};
  // Reserve FIFO space for every read in flight so returns can never overflow.
  assign mem_req   = (state == S_FETCH) && (committed < DEPTH_L);
  assign accept    = mem_req && mem_ready;
  assign ret_live  = mem_rvalid && (discard == '0);
  assign do_push   = ret_live && !screenend;
  assign do_pop    = active && !screenend && (state != S_IDLE) && (fifo_level != '0);

  // Reads still owed by memory from before a flush; their data must be dropped.
  assign stale      = discard + DISC_W'(outstanding) + DISC_W'(accept);
  assign stale_next = (mem_rvalid && (stale != '0)) ? stale - 1'b1 : stale;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_level  <= '0;
      outstanding <= '0;
      discard     <= '0;
      pix_cnt     <= '0;
      mem_addr    <= FB_BASE;
      color_out   <= '0;
      underflow   <= 1'b0;
    end else if (screenend) begin
      state       <= S_FETCH;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_level  <= '0;
      outstanding <= '0;
      discard     <= stale_next;
      pix_cnt     <= '0;
      mem_addr    <= FB_BASE;
      color_out   <= '0;
    end else begin
      if (active && (state != S_IDLE)) begin
        if (fifo_level != '0) begin
          color_out <= fifo_mem[rd_ptr];
        end else begin
          color_out <= UNDERFLOW_COLOR;
          underflow <= 1'b1;
        end
      end else begin
        color_out <= '0;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (accept && !ret_live)      outstanding <= outstanding + 1'b1;
      else if (!accept && ret_live) outstanding <= outstanding - 1'b1;

      if (mem_rvalid && (discard != '0)) discard <= discard - 1'b1;

      if (accept) begin
        mem_addr <= mem_addr + 1'b1;
        pix_cnt  <= pix_cnt + 1'b1;
        if (pix_cnt == LAST_PIX) state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized bench for vga_pixel_fetch: a latency-modelled memory plus a
// frame-epoch reference model feeding an expected-colour queue.
module tb_vga_pixel_fetch;

  localparam int          H      = 8;
  localparam int          V      = 4;
  localparam int          TOTAL  = H * V;
  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 20;
  localparam int          LVL_W  = $clog2(DEPTH) + 1;
  localparam logic [19:0] BASE   = 20'h00100;
  localparam logic [23:0] UF_COL = 24'hFF00FF;

  logic              clk;
  logic              rst_n;
  logic              screenend;
  logic              active;
  logic [23:0]       color_out;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [23:0]       mem_rdata;
  logic              underflow;
  logic [LVL_W-1:0]  fifo_level;
  logic [1:0]        dbg_state;

  vga_pixel_fetch #(
    .H_VISIBLE(H), .V_VISIBLE(V), .ADDR_W(ADDR_W), .FB_BASE(BASE),
    .FIFO_DEPTH(DEPTH), .UNDERFLOW_COLOR(UF_COL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .screenend(screenend), .active(active),
    .color_out(color_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .underflow(underflow), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int cyc;

  // memory in flight: data, frame epoch at acceptance, earliest return cycle
  logic [23:0] fl_data[$];
  int          fl_tag[$];
  int          fl_due[$];

  // reference model
  logic [23:0] model_q[$];
  logic [23:0] exp_q[$];
  int          epoch;
  int          acc_cnt;
  int          ret_cnt;
  bit          started;
  bit          done;
  bit          uf_m;

  function automatic logic [23:0] pix_data(input int a);
    return 24'(a * 40503 + 961);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    fl_data.delete(); fl_tag.delete(); fl_due.delete();
    model_q.delete();
    acc_cnt = 0; ret_cnt = 0; started = 0; done = 0; uf_m = 0;
  endtask

  // Called at a negedge: checks registered outputs, drives the next edge, updates the model.
  task automatic step(input bit se, input bit act, input int rdy_pct, input int lat, input int rv_pct);
    int          cur;
    int          rtag;
    bit          exp_req;
    bit          rdy;
    bit          rv;
    bit          acc;
    logic [23:0] exp_c;
    cur = 0;
    foreach (fl_tag[i]) if (fl_tag[i] == epoch) cur++;
    exp_req = started && !done && (model_q.size() + cur < DEPTH);
    check("fifo_level", 32'(fifo_level), 32'(model_q.size()));
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req && mem_req) check("mem_addr", 32'(mem_addr), 32'(BASE) + 32'(acc_cnt));
    check("underflow", 32'(underflow), 32'(uf_m));
    check("state", 32'(dbg_state), !started ? 32'd0 : (done ? 32'd2 : 32'd1));

    rdy = ($urandom_range(0, 99) < rdy_pct);
    rv  = (fl_data.size() > 0) && (fl_due[0] <= cyc + 1) && ($urandom_range(0, 99) < rv_pct);
    screenend  = se;
    active     = act;
    mem_ready  = rdy;
    mem_rvalid = rv;
    mem_rdata  = rv ? fl_data[0] : 24'($urandom);
    acc = mem_req && rdy;

    exp_c = '0;
    if (!se && started && act) begin
      if (model_q.size() > 0) exp_c = model_q.pop_front();
      else begin
        exp_c = UF_COL;
        uf_m  = 1;
      end
    end
    if (rv) begin
      rtag = fl_tag[0];
      void'(fl_data.pop_front()); void'(fl_tag.pop_front()); void'(fl_due.pop_front());
      if (!se && rtag == epoch) begin
        model_q.push_back(pix_data(int'(BASE) + ret_cnt));
        ret_cnt++;
      end
    end
    if (acc) begin
      fl_data.push_back(pix_data(int'(mem_addr)));
      fl_tag.push_back(epoch);
      fl_due.push_back(cyc + 1 + lat);
    end
    if (se) begin
      model_q.delete();
      epoch++;
      acc_cnt = 0; ret_cnt = 0; started = 1; done = 0;
    end else if (acc) begin
      acc_cnt++;
      if (acc_cnt == TOTAL) done = 1;
    end
    exp_q.push_back(exp_c);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; screenend = 0; active = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    #1;
    check("rst_color_out", 32'(color_out), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    clear_model();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // act_pct < 0 selects 8-cycle active bursts after a 40-cycle prefill
  task automatic run_phase(input int n, input int lat_lo, input int lat_hi, input int rdy,
                           input int rv, input int act_pct, input int se_pm, input int se_at,
                           input bit first_se);
    for (int i = 0; i < n; i++) begin
      bit se;
      bit act;
      se = (first_se && i == 0) || (i == se_at) || ($urandom_range(0, 999) < se_pm);
      if (act_pct < 0) act = (i >= 40) && (((i / 8) % 2) == 1);
      else             act = ($urandom_range(0, 99) < act_pct);
      if (i == se_at) act = 1'b1;
      step(se, act, rdy, $urandom_range(lat_lo, lat_hi), rv);
    end
  endtask

  // monitor: compares color_out after every driven edge
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("color_out", 32'(color_out), 32'(e));
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; epoch = 0;
    rst_n = 1'b0; screenend = 0; active = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    clear_model();
    @(negedge clk);
    do_reset();
    run_phase(5, 3, 3, 100, 100, 0, 0, -1, 0);      // idle after reset: no requests
    run_phase(80, 3, 3, 100, 100, 0, 0, -1, 1);     // prefill to full, requests stop
    run_phase(300, 3, 3, 100, 100, -1, 0, -1, 1);   // whole frame in bursts, reaches DONE
    run_phase(200, 40, 40, 100, 100, 100, 0, -1, 1);// long latency: sticky underflow
    run_phase(200, 1, 8, 70, 70, 50, 30, -1, 1);
    do_reset();                                     // mid-frame reset
    run_phase(10, 1, 8, 70, 70, 50, 0, -1, 0);
    run_phase(40, 12, 12, 100, 100, 0, 0, 7, 1);    // flush with reads outstanding
    run_phase(150, 1, 4, 100, 100, 60, 0, -1, 0);
    run_phase(600, 1, 20, 50, 60, 40, 20, -1, 1);
    run_phase(300, 1, 40, 80, 80, 30, 10, -1, 1);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
